// File: rtl/isa_control_unit.sv
// Hardwired control sequencer for a single-bus datapath.
// Steps fetch (T0-T3) then per-opcode execute steps (T4-T8), stalling on mem_done.
module isa_control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        con_ff,
    input  logic        mem_done,
    output logic        PCout,
    output logic        IncPC,
    output logic        PCin,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        CONin,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_T0    = 5'd1,
        S_T1    = 5'd2,
        S_T2    = 5'd3,
        S_T3    = 5'd4,
        S_T4    = 5'd5,
        S_T5    = 5'd6,
        S_T6    = 5'd7,
        S_T7    = 5'd8,
        S_T8    = 5'd9,
        S_HALT  = 5'd10
    } state_t;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_BR   = 5'd18;
    localparam logic [4:0] OP_HALT = 5'd26;

    state_t     state_q, state_d;
    logic [4:0] op_q, op_d;

    logic is_r, is_imm, is_addr, is_br;
    logic unused_ir_bits;

    assign unused_ir_bits = ^IR[26:0];

    // Opcode is captured in T3 so later IR changes cannot disturb the execute steps.
    assign is_r    = (op_q >= 5'd3) && (op_q <= 5'd10);
    assign is_imm  = (op_q >= 5'd11) && (op_q <= 5'd13);
    assign is_addr = (op_q == OP_LD) || (op_q == OP_LDI) || (op_q == OP_ST);
    assign is_br   = (op_q == OP_BR);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_RESET;
            op_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = S_T2;
            S_T2:    state_d = mem_done ? S_T3 : S_T2;
            S_T3: begin
                op_d = IR[31:27];
                if ((IR[31:27] <= 5'd13) || (IR[31:27] == OP_BR))
                    state_d = S_T4;
                else if (IR[31:27] == OP_HALT)
                    state_d = S_HALT;
                else
                    state_d = S_T0;
            end
            S_T4:    state_d = S_T5;
            S_T5:    state_d = S_T6;
            S_T6:    state_d = (op_q == OP_LD || op_q == OP_ST || is_br) ? S_T7 : S_T0;
            S_T7: begin
                if (op_q == OP_LD)
                    state_d = mem_done ? S_T8 : S_T7;
                else if (op_q == OP_ST)
                    state_d = S_T8;
                else
                    state_d = S_T0;
            end
            S_T8: begin
                if (op_q == OP_ST)
                    state_d = mem_done ? S_T0 : S_T8;
                else
                    state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0;
        Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        alu_op = 5'd0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; end
            S_T2: begin Read = 1'b1; MDRin = 1'b1; end
            S_T3: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T4: begin
                if (is_br) begin
                    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                end else if (is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_r || is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end
            end
            S_T5: begin
                if (is_br) begin
                    PCout = 1'b1; Yin = 1'b1;
                end else if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_q;
                end else if (is_imm) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = op_q;
                end else if (is_addr) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
                end
            end
            S_T6: begin
                if (is_br) begin
                    Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD;
                end else if (op_q == OP_LD || op_q == OP_ST) begin
                    Zlowout = 1'b1; MARin = 1'b1;
                end else begin
                    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            S_T7: begin
                if (op_q == OP_LD) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (op_q == OP_ST) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end else if (is_br) begin
                    Zlowout = 1'b1; PCin = con_ff;
                end
            end
            S_T8: begin
                if (op_q == OP_LD) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (op_q == OP_ST) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign run   = (state_q != S_HALT);
    assign state = state_q;

endmodule

// File: tb/tb_isa_control_unit.sv
// Randomized bench for isa_control_unit: a step-list model of each instruction's
// control sequence is compared cycle by cycle against the DUT strobes.
module tb_isa_control_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR = 32'd0;
    logic        con_ff = 1'b0;
    logic        mem_done = 1'b0;
    logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, CONin;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
    logic [4:0] alu_op, state;
    logic [19:0] obs;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [19:0] M_PCOUT   = 20'd1 << 19;
    localparam logic [19:0] M_INCPC   = 20'd1 << 18;
    localparam logic [19:0] M_PCIN    = 20'd1 << 17;
    localparam logic [19:0] M_MARIN   = 20'd1 << 16;
    localparam logic [19:0] M_MDRIN   = 20'd1 << 15;
    localparam logic [19:0] M_MDROUT  = 20'd1 << 14;
    localparam logic [19:0] M_IRIN    = 20'd1 << 13;
    localparam logic [19:0] M_YIN     = 20'd1 << 12;
    localparam logic [19:0] M_ZIN     = 20'd1 << 11;
    localparam logic [19:0] M_ZLOWOUT = 20'd1 << 10;
    localparam logic [19:0] M_COUT    = 20'd1 << 9;
    localparam logic [19:0] M_CONIN   = 20'd1 << 8;
    localparam logic [19:0] M_READ    = 20'd1 << 7;
    localparam logic [19:0] M_WRITE   = 20'd1 << 6;
    localparam logic [19:0] M_GRA     = 20'd1 << 5;
    localparam logic [19:0] M_GRB     = 20'd1 << 4;
    localparam logic [19:0] M_GRC     = 20'd1 << 3;
    localparam logic [19:0] M_RIN     = 20'd1 << 2;
    localparam logic [19:0] M_ROUT    = 20'd1 << 1;
    localparam logic [19:0] M_BAOUT   = 20'd1 << 0;

    typedef struct packed {
        logic [19:0] s;
        logic [4:0]  alu;
        logic        done;
        logic        pre;
        logic        rn;
    } step_t;

    step_t exp_q[$];

    isa_control_unit dut (
        .clk(clk), .clr(clr), .IR(IR), .con_ff(con_ff), .mem_done(mem_done),
        .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .CONin(CONin), .Read(Read), .Write(Write), .Gra(Gra),
        .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run), .state(state)
    );

    assign obs = {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                  Cout, CONin, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout};

    always #5 clk = ~clk;

    task automatic push(input logic [19:0] s, input logic [4:0] alu, input logic done,
                        input logic pre, input logic rn);
        step_t e;
        e.s = s; e.alu = alu; e.done = done; e.pre = pre; e.rn = rn;
        exp_q.push_back(e);
    endtask

    // Non-wait steps get random mem_done, which the sequencer must ignore.
    task automatic push_plain(input logic [19:0] s, input logic [4:0] alu);
        push(s, alu, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    endtask

    task automatic push_wait(input logic [19:0] s, input int waits);
        repeat (waits) push(s, 5'd0, 1'b0, 1'b0, 1'b1);
        push(s, 5'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic build(input logic [31:0] ir, input logic con, input int w2, input int wm);
        logic [4:0] op;
        op = ir[31:27];
        push_plain(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0);
        push_plain(M_ZLOWOUT | M_PCIN, 5'd0);
        push_wait(M_READ | M_MDRIN, w2);
        push(M_MDROUT | M_IRIN, 5'd0, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
        if (op >= 5'd3 && op <= 5'd10) begin
            push_plain(M_GRB | M_ROUT | M_YIN, 5'd0);
            push_plain(M_GRC | M_ROUT | M_ZIN, op);
            push_plain(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
        end else if (op >= 5'd11 && op <= 5'd13) begin
            push_plain(M_GRB | M_ROUT | M_YIN, 5'd0);
            push_plain(M_COUT | M_ZIN, op);
            push_plain(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
        end else if (op <= 5'd2) begin
            push_plain(M_GRB | M_BAOUT | M_YIN, 5'd0);
            push_plain(M_COUT | M_ZIN, 5'd3);
            if (op == 5'd1) begin
                push_plain(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
            end else if (op == 5'd0) begin
                push_plain(M_ZLOWOUT | M_MARIN, 5'd0);
                push_wait(M_READ | M_MDRIN, wm);
                push_plain(M_MDROUT | M_GRA | M_RIN, 5'd0);
            end else begin
                push_plain(M_ZLOWOUT | M_MARIN, 5'd0);
                push_plain(M_GRA | M_ROUT | M_MDRIN, 5'd0);
                push_wait(M_WRITE, wm);
            end
        end else if (op == 5'd18) begin
            push_plain(M_GRA | M_ROUT | M_CONIN, 5'd0);
            push_plain(M_PCOUT | M_YIN, 5'd0);
            push_plain(M_COUT | M_ZIN, 5'd3);
            push_plain(M_ZLOWOUT | (con ? M_PCIN : 20'd0), 5'd0);
        end else if (op == 5'd26) begin
            repeat (6) push(20'd0, 5'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    // IR is only valid in T3; elsewhere it is scrambled to prove dispatch uses the T3 sample.
    task automatic run_steps(input logic [31:0] ir, input logic con, input int n);
        step_t e;
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            IR = e.pre ? ir : $urandom;
            con_ff = con;
            mem_done = e.done;
            #1;
            vectors++;
            if (obs !== e.s) begin
                miscompares++;
                $display("[TB] FAIL strobes ir=%h step=%0d: got %b want %b", ir, k, obs, e.s);
            end
            vectors++;
            if (alu_op !== e.alu) begin
                miscompares++;
                $display("[TB] FAIL alu_op ir=%h step=%0d: got %b want %b", ir, k, alu_op, e.alu);
            end
            vectors++;
            if (run !== e.rn) begin
                miscompares++;
                $display("[TB] FAIL run ir=%h step=%0d: got %b want %b", ir, k, run, e.rn);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exec(input logic [31:0] ir, input logic con, input int w2, input int wm);
        build(ir, con, w2, wm);
        run_steps(ir, con, exp_q.size());
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        clr = 1'b1; mem_done = 1'b1;
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_assert: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        clr = 1'b0; mem_done = 1'b0;
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        exec({5'd25, 27'($urandom)}, 1'b0, 0, 0);
    endtask

    task automatic test_r_format;
        exec(32'h19890000, 1'b0, 0, 0);
        repeat (6) exec({5'($urandom_range(3, 10)), 27'($urandom)}, 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), 0);
    endtask

    task automatic test_immediate;
        repeat (5) exec({5'($urandom_range(11, 13)), 27'($urandom)}, 1'b0, $urandom_range(0, 2), 0);
    endtask

    task automatic test_ldi;
        repeat (3) exec({5'd1, 27'($urandom)}, 1'b0, $urandom_range(0, 2), 0);
    endtask

    task automatic test_ld;
        exec(32'h01000055, 1'b0, 0, 3);
        repeat (3) exec({5'd0, 27'($urandom)}, 1'b0, $urandom_range(0, 3), $urandom_range(0, 4));
    endtask

    task automatic test_st;
        repeat (4) exec({5'd2, 27'($urandom)}, 1'b0, $urandom_range(0, 3), $urandom_range(0, 4));
    endtask

    task automatic test_branch;
        exec(32'h90000000, 1'b0, 0, 0);
        exec(32'h90000000, 1'b1, 0, 0);
        repeat (4) exec({5'd18, 27'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    endtask

    task automatic test_nop_unlisted;
        logic [4:0] op;
        exec({5'd25, 27'($urandom)}, 1'b0, 0, 0);
        exec({5'd31, 27'($urandom)}, 1'b0, 1, 0);
        repeat (6) begin
            op = 5'($urandom_range(14, 31));
            if (op == 5'd18 || op == 5'd26) op = 5'd31;
            exec({op, 27'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
        end
    endtask

    task automatic test_reset_mid_ld;
        build(32'h01000055, 1'b0, 0, 5);
        run_steps(32'h01000055, 1'b0, 7);
        exp_q.delete();
        IR = $urandom; mem_done = 1'b0;
        #1;
        vectors++;
        if (obs !== (M_READ | M_MDRIN)) begin
            miscompares++;
            $display("[TB] FAIL mid_ld_t7: got %b want %b", obs, M_READ | M_MDRIN);
        end
        #1;
        clr = 1'b1; mem_done = 1'b1;
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL mid_ld_clr: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL mid_ld_hold: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        clr = 1'b0; mem_done = 1'b0;
        @(posedge clk);
        #1;
        exec({5'd3, 27'($urandom)}, 1'b0, 0, 0);
    endtask

    task automatic test_halt;
        exec(32'hD0000000, 1'b0, 1, 0);
        clr = 1'b1; mem_done = 1'b1;
        #1;
        vectors++;
        if ({obs, alu_op, run} !== {25'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL halt_clr: got %h want %h", {obs, alu_op, run}, {25'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        clr = 1'b0; mem_done = 1'b0;
        @(posedge clk);
        #1;
        exec({5'd25, 27'($urandom)}, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back;
        logic [4:0] op;
        repeat (25) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26) op = 5'd25;
            exec({op, 27'($urandom)}, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_r_format();
        test_immediate();
        test_ldi();
        test_ld();
        test_st();
        test_branch();
        test_nop_unlisted();
        test_reset_mid_ld();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
